// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
module mdu_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Result datapath from latched operands. Signed division is done on magnitudes and
    // the signs re-applied, so MIN_INT / -1 naturally wraps to MIN_INT with remainder 0.
    always_comb begin
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
        b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
        a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
        // A zero divisor never commits a result; substituting 1 keeps the divider defined.
        b_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem    = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    // Issue, countdown and HI/LO commit; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            HI   <= '0;
            LO   <= '0;
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    cnt  <= '0;
                    case (op_q)
                        OP_MULT:  {HI, LO} <= prod_s;
                        OP_MULTU: {HI, LO} <= prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != '0) begin
                                HI <= rem;
                                LO <= quot;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else if (start) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        op_q <= op;
                        a_q  <= A;
                        b_q  <= B;
                        cnt  <= CW'(MUL_CYCLES);
                        busy <= 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        op_q <= op;
                        a_q  <= A;
                        b_q  <= B;
                        cnt  <= CW'(DIV_CYCLES);
                        busy <= 1'b1;
                    end
                    OP_MTHI: HI <= A;
                    OP_MTLO: LO <= A;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed scoreboard bench for mdu_unit
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
        longint          x;
        longint          y;
        longint          q;
        longint          r;
        longint unsigned pu;
        logic [63:0]     res;
        res = {hi, lo};
        case (o)
            3'd1: begin
                x   = longint'($signed(a));
                y   = longint'($signed(b));
                res = 64'(x * y);
            end
            3'd2: begin
                pu  = {32'b0, a} * {32'b0, b};
                res = pu;
            end
            3'd3: if (b != 0) begin
                x   = longint'($signed(a));
                y   = longint'($signed(b));
                q   = x / y;
                r   = x % y;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) res = {a % b, a / b};
            default: ;
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (o inside {3'd1, 3'd2, 3'd3, 3'd4}) sb.push_back(model(o, a, b, m_hi, m_lo));
        else if (o == 3'd5) m_hi = a;
        else if (o == 3'd6) m_lo = a;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic finish_op(input string tag, input int exp_cycles, input bit inject);
        int          n;
        logic [63:0] e;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (inject && n == 2) begin
                start = 1'b1;
                op    = 3'd6;
                A     = 32'h0000DEAD;
            end else begin
                start = 1'b0;
                op    = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op    = 3'd0;
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_cycles));
        check({tag, " done_pulse"}, 64'(done), 64'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        check({tag, " hilo"}, {HI, LO}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
        @(negedge clk);
        check({tag, " done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {HI, LO}, 64'd0);
        reset = 1'b0;

        issue(3'd1, 32'hFFFFFFFD, 32'd7);
        finish_op("mult", 5, 1'b0);
        check("mult const", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);

        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu", 5, 1'b0);
        check("multu const", {HI, LO}, 64'hFFFFFFFE_00000001);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        finish_op("div", 10, 1'b0);
        check("div const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

        issue(3'd4, 32'd7, 32'd2);
        finish_op("divu", 10, 1'b0);
        check("divu const", {HI, LO}, 64'h00000001_00000003);

        issue(3'd5, 32'h11, 32'd0);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi hi", 64'(HI), 64'h11);
        issue(3'd6, 32'h22, 32'd0);
        check("mtlo done", 64'(done), 64'd0);
        check("mtlo lo", 64'(LO), 64'h22);
        issue(3'd3, 32'd5, 32'd0);
        finish_op("div0", 10, 1'b0);
        check("div0 const", {HI, LO}, 64'h00000011_00000022);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div minint", 10, 1'b0);
        check("div minint const", {HI, LO}, 64'h00000000_80000000);

        issue(3'd1, 32'h1234, 32'h10);
        finish_op("mult ignore_mtlo", 5, 1'b1);
        check("mult ignore const", {HI, LO}, 64'h00000000_00012340);
        issue(3'd5, 32'h12345678, 32'd0);
        check("idle mthi busy", 64'(busy), 64'd0);
        check("idle mthi hi", 64'(HI), 64'h12345678);

        for (int i = 0; i < 6; i++) begin
            ro = 3'(1 + (i % 4));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            issue(ro, ra, rb);
            finish_op("random op", (ro < 3'd3) ? 5 : 10, 1'b0);
        end

        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midop reset busy", 64'(busy), 64'd0);
        check("midop reset done", 64'(done), 64'd0);
        check("midop reset hilo", {HI, LO}, 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post reset quiet", {30'd0, busy, done, HI}, {30'd0, 2'b00, m_hi});
            check("post reset lo", 64'(LO), 64'(m_lo));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
